snn_timestep_sequencer: RTL and testbench

//  Consumes ctrl[31:0] from the AXI config register block and runs one SNN inference as N discrete timesteps.
//  Per run: clears neuron state, issues one net_step pulse per timestep, waits for the network's net_step_done,

---
 rtl/snn_timestep_sequencer.sv | 155 +++++++++++++++
 tb/tb_snn_timestep_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/snn_timestep_sequencer.sv
// ============================================================================
// snn_timestep_sequencer: runs one SNN inference as num_ts timesteps with clear/step/wait/settle
// Optional macro: SNN_SEQ_ABORT_EN (ctrl[1] abort). Revision 1.0
// ============================================================================
`default_nettype none

module snn_timestep_sequencer #(
  parameter int CLEAR_CYCLES = 4,
  parameter int TIMEOUT_W    = 10
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] ctrl,
  input  logic        net_step_done,
  output logic        net_clear,
  output logic        net_step,
  output logic [7:0]  timestep,
  output logic        busy,
  output logic        done_irq,
  output logic [31:0] status
);

  localparam int CW = $clog2(CLEAR_CYCLES + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_STEP   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_SETTLE = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  logic [2:0]           state;
  logic                 ctrl0_q;
  logic [7:0]           num_ts_q;
  logic [7:0]           settle_q;
  logic [CW-1:0]        clr_cnt;
  logic [7:0]           settle_cnt;
  logic [TIMEOUT_W-1:0] watchdog;
  logic                 done_flag;
  logic                 timeout_flag;
  logic                 aborted_flag;

  logic                 start;
  logic                 last_ts;
  logic [TIMEOUT_W-1:0] wd_next;
  logic                 wd_expire;
  logic                 abort_req;

  assign start     = ctrl[0] & ~ctrl0_q;
  assign last_ts   = (timestep == num_ts_q - 8'd1);
  assign wd_next   = watchdog + TIMEOUT_W'(1);
  assign wd_expire = &wd_next;

`ifdef SNN_SEQ_ABORT_EN
  assign abort_req = ctrl[1] && (state != S_IDLE) && (state != S_DONE);
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl[31:24], ctrl[7:2]};
`else
  assign abort_req = 1'b0;
  logic unused_ctrl;
  assign unused_ctrl = ^{ctrl[31:24], ctrl[7:1]};
`endif

  assign net_clear = (state == S_CLEAR);
  assign net_step  = (state == S_STEP);
  assign busy      = (state != S_IDLE);
  assign status    = {12'b0, aborted_flag, timeout_flag, done_flag, busy,
                      5'b0, state, timestep};

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state        <= S_IDLE;
      ctrl0_q      <= 1'b0;
      num_ts_q     <= 8'd0;
      settle_q     <= 8'd0;
      clr_cnt      <= '0;
      settle_cnt   <= 8'd0;
      watchdog     <= '0;
      done_flag    <= 1'b0;
      timeout_flag <= 1'b0;
      aborted_flag <= 1'b0;
      timestep     <= 8'd0;
      done_irq     <= 1'b0;
    end else begin
      ctrl0_q  <= ctrl[0];
      done_irq <= 1'b0;
      if (abort_req) begin
        // Abort outranks a same-cycle net_step_done or watchdog expiry.
        state        <= S_IDLE;
        aborted_flag <= 1'b1;
        done_flag    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              num_ts_q     <= ctrl[15:8];
              settle_q     <= ctrl[23:16];
              done_flag    <= 1'b0;
              timeout_flag <= 1'b0;
              aborted_flag <= 1'b0;
              timestep     <= 8'd0;
              clr_cnt      <= CW'(CLEAR_CYCLES - 1);
              state        <= (ctrl[15:8] == 8'd0) ? S_DONE : S_CLEAR;
            end
          end
          S_CLEAR: begin
            if (clr_cnt == '0) state <= S_STEP;
            else               clr_cnt <= clr_cnt - CW'(1);
          end
          S_STEP: begin
            watchdog <= '0;
            state    <= S_WAIT;
          end
          S_WAIT: begin
            watchdog <= wd_next;
            if (net_step_done) begin
              if (settle_q != 8'd0) begin
                settle_cnt <= settle_q - 8'd1;
                state      <= S_SETTLE;
              end else if (last_ts) begin
                state <= S_DONE;
              end else begin
                timestep <= timestep + 8'd1;
                state    <= S_STEP;
              end
            end else if (wd_expire) begin
              timeout_flag <= 1'b1;
              state        <= S_DONE;
            end
          end
          S_SETTLE: begin
            if (settle_cnt != 8'd0) begin
              settle_cnt <= settle_cnt - 8'd1;
            end else if (last_ts) begin
              state <= S_DONE;
            end else begin
              timestep <= timestep + 8'd1;
              state    <= S_STEP;
            end
          end
          S_DONE: begin
            // The irq/flag register lands the cycle after DONE, when the FSM is back in IDLE.
            done_irq  <= 1'b1;
            done_flag <= 1'b1;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_snn_timestep_sequencer.sv
// ============================================================================
// tb_snn_timestep_sequencer: randomized and directed runs checked against a timeline model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_snn_timestep_sequencer;

  localparam int CLEAR = 4;
  localparam int WD_LIMIT = 1023;
`ifdef SNN_SEQ_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ctrl;
  logic        nsd;
  logic        net_clear, net_step, busy, done_irq;
  logic [7:0]  timestep;
  logic [31:0] status;

  int errors = 0;
  int checks = 0;
  int dly [0:255];

  always #5 clk = ~clk;

  snn_timestep_sequencer #(.CLEAR_CYCLES(CLEAR), .TIMEOUT_W(10)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .ctrl          (ctrl),
    .net_step_done (nsd),
    .net_clear     (net_clear),
    .net_step      (net_step),
    .timestep      (timestep),
    .busy          (busy),
    .done_irq      (done_irq),
    .status        (status)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Timeline model: interval 0 drives the start edge; every later interval is one clock.
  task automatic do_run(input string tag, input int n, input int s, input int hold,
                        input bit mid_start, input int abort_at);
    int  exp_step[$];
    int  act_step[$];
    int  act_ts[$];
    int  act_irq[$];
    int  resp[$];
    int  exp_irq, exp_last, t, budget, clr_n, clr_first;
    bit  exp_to, aborting;
    logic [31:0] exp_status;
    aborting = (abort_at >= 0) && ABORT_EN;
    exp_to = 1'b0;
    exp_irq = 2;
    exp_last = 0;
    t = 1 + CLEAR;
    for (int i = 0; i < n; i++) begin
      exp_step.push_back(t);
      exp_last = i;
      if (dly[i] > WD_LIMIT) begin
        exp_to = 1'b1;
        exp_irq = t + WD_LIMIT + 2;
        break;
      end else if (i == n - 1) begin
        exp_irq = t + dly[i] + s + 2;
      end else begin
        t = t + dly[i] + s + 1;
      end
    end
    if (aborting) begin
      while (exp_step.size() > 0 && exp_step[exp_step.size()-1] >= abort_at)
        void'(exp_step.pop_back());
      exp_last = exp_step.size() - 1;
      budget = abort_at + 10;
    end else begin
      budget = exp_irq + 8;
    end

    ctrl = {8'h00, 8'(s), 8'(n), 8'h01};
    nsd = 1'b0;
    clr_n = 0;
    clr_first = -1;
    for (int rel = 1; rel <= budget; rel++) begin
      tick();
      if (net_step) begin
        act_step.push_back(rel);
        act_ts.push_back(int'(timestep));
        if (act_step.size() <= 256) resp.push_back(rel + dly[act_step.size()-1]);
      end
      if (net_clear) begin
        clr_n++;
        if (clr_first < 0) clr_first = rel;
      end
      if (done_irq) act_irq.push_back(rel);
      nsd = 1'b0;
      foreach (resp[k]) if (resp[k] == rel) nsd = 1'b1;
      if (rel == hold) ctrl[0] = 1'b0;
      if (mid_start && rel == hold + 2) begin
        ctrl[0] = 1'b1;
        ctrl[15:8] = 8'd9;
      end
      if (mid_start && rel == hold + 3) ctrl[0] = 1'b0;
      if (rel == abort_at) ctrl[1] = 1'b1;
      if (rel == abort_at + 1) begin
        ctrl[1] = 1'b0;
        if (aborting) begin
          chk({tag, "_abort_flags"}, {28'b0, status[19:16]}, 32'h8);
          chk({tag, "_abort_state"}, {29'b0, status[10:8]}, 32'h0);
        end
      end
    end
    ctrl = 32'h0;
    nsd = 1'b0;

    chk({tag, "_nsteps"}, act_step.size(), exp_step.size());
    for (int i = 0; i < exp_step.size() && i < act_step.size(); i++) begin
      chk($sformatf("%s_step%0d_time", tag, i), act_step[i], exp_step[i]);
      chk($sformatf("%s_step%0d_ts", tag, i), act_ts[i], i);
    end
    chk({tag, "_clear_cycles"}, clr_n, (n > 0) ? CLEAR : 0);
    if (n > 0) chk({tag, "_clear_first"}, clr_first, 1);
    chk({tag, "_nirq"}, act_irq.size(), aborting ? 0 : 1);
    if (!aborting && act_irq.size() > 0) chk({tag, "_irq_time"}, act_irq[0], exp_irq);
    exp_status = {12'b0, aborting, exp_to & ~aborting, ~aborting, 1'b0,
                  5'b0, 3'b0, 8'(exp_last)};
    chk({tag, "_status"}, status, exp_status);
  endtask

  initial begin
    int n, s, ab;
    rst_n = 1'b0;
    ctrl = 32'h0;
    nsd = 1'b0;
    repeat (3) tick();
    chk("reset_status", status, 32'h0);
    chk("reset_outs", {net_clear, net_step, busy, done_irq}, 4'h0);
    chk("reset_ts", timestep, 8'h0);
    rst_n = 1'b1;
    tick();

    // Reset mid-WAIT: first net_step at interval 5, WAIT from interval 6.
    ctrl = {8'h00, 8'd1, 8'd3, 8'h01};
    repeat (7) tick();
    chk("t1_in_wait", {29'b0, status[10:8]}, 32'd3);
    rst_n = 1'b0;
    ctrl = 32'h0;
    tick();
    chk("t1_status", status, 32'h0);
    chk("t1_outs", {net_clear, net_step, busy, done_irq, timestep}, 12'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_after", status, 32'h0);

    // Nominal: three timesteps, settle 2, network replies after 5 cycles.
    for (int i = 0; i < 256; i++) dly[i] = 5;
    do_run("t2", 3, 2, 1, 1'b0, -1);
    // num_ts = 0 goes straight to DONE.
    do_run("t3", 0, 3, 1, 1'b0, -1);
    // Timeout: reply never comes in time.
    dly[0] = 2000;
    do_run("t4", 2, 1, 1, 1'b0, -1);
    // Reply on the very last watchdog cycle still counts as done.
    dly[0] = WD_LIMIT;
    do_run("wd_edge", 1, 0, 1, 1'b0, -1);
    // Held start, second start and num_ts change mid-run.
    for (int i = 0; i < 256; i++) dly[i] = 12;
    do_run("t5", 4, 5, 50, 1'b1, -1);
    // Full-range run with no settle.
    for (int i = 0; i < 256; i++) dly[i] = 1;
    do_run("ts255", 255, 0, 1, 1'b0, -1);

    // Abort during SETTLE of timestep 1 (ignored in builds without the abort feature).
    for (int i = 0; i < 256; i++) dly[i] = 3;
    ab = (1 + CLEAR) + dly[0] + 2 + 1 + dly[1] + 1;
    do_run("t6", 4, 2, 1, 1'b0, ab);
    do_run("t6_rerun", 2, 1, 1, 1'b0, -1);

    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 6);
      s = $urandom_range(0, 4);
      for (int i = 0; i < 256; i++) dly[i] = $urandom_range(1, 10);
      do_run($sformatf("rnd%0d", r), n, s, $urandom_range(1, 4), 1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
